// File: rtl/heroe_pkg.sv
// Shared game-state codes and helpers for the game controller and the collision checker.
package heroe_pkg;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    WLCM = 3'd1,
    CH   = 3'd2,
    GAME = 3'd3,
    WL   = 3'd4,
    PA   = 3'd5
  } estado_t;

  localparam int unsigned TIMER_W = 28;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOST = 2'b01;
  localparam logic [1:0] RES_WON  = 2'b10;

  // Character selection cycles 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] siguiente_personaje(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for one asynchronous bit into the clk domain.
module sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/control_juego.sv
// Game controller: power/welcome/character/game/pause/result flow, world progress and bonus score.
module control_juego
  import heroe_pkg::*;
#(
  parameter int unsigned PASOS_MUNDO = 32,
  parameter int unsigned T_WLCM      = 50_000_000,
  parameter int unsigned T_WL        = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic       btn_start,
  input  logic       btn_pausa,
  input  logic       btn_select,
  input  logic       tick_obs,
  input  logic [1:0] W_or_L,
  input  logic       bono_tomado,
  output logic [2:0] presente,
  output logic [1:0] mundo,
  output logic [1:0] personaje,
  output logic [7:0] puntaje,
  output logic [1:0] resultado,
  output logic       en_obs
);

  localparam int unsigned PASO_W = (PASOS_MUNDO > 1) ? $clog2(PASOS_MUNDO) : 1;

  estado_t              state_q, state_d;
  logic [PASO_W-1:0]    paso_q, paso_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [1:0]           mundo_d, personaje_d, resultado_d;
  logic [7:0]           puntaje_d;
  logic [1:0]           wl_s;
  logic                 bono_s, bono_prev, bono_flanco;

  sincronizador u_sync_wl0  (.clk(clk), .rst(rst), .d(W_or_L[0]),  .q(wl_s[0]));
  sincronizador u_sync_wl1  (.clk(clk), .rst(rst), .d(W_or_L[1]),  .q(wl_s[1]));
  sincronizador u_sync_bono (.clk(clk), .rst(rst), .d(bono_tomado), .q(bono_s));

  assign bono_flanco = bono_s & ~bono_prev;
  assign presente    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      paso_q    <= '0;
      timer_q   <= '0;
      mundo     <= 2'd0;
      personaje <= 2'd0;
      puntaje   <= 8'd0;
      resultado <= RES_NONE;
      en_obs    <= 1'b0;
      bono_prev <= 1'b0;
    end else begin
      state_q   <= state_d;
      paso_q    <= paso_d;
      timer_q   <= timer_d;
      mundo     <= mundo_d;
      personaje <= personaje_d;
      puntaje   <= puntaje_d;
      resultado <= resultado_d;
      en_obs    <= (state_d == GAME);
      bono_prev <= bono_s;
    end
  end

  // Next state and datapath; power-off outranks everything outside OFF.
  always_comb begin
    state_d     = state_q;
    paso_d      = paso_q;
    timer_d     = timer_q;
    mundo_d     = mundo;
    personaje_d = personaje;
    puntaje_d   = puntaje;
    resultado_d = resultado;

    if (state_q != OFF && btn_power) begin
      state_d     = OFF;
      paso_d      = '0;
      timer_d     = '0;
      mundo_d     = 2'd0;
      puntaje_d   = 8'd0;
      resultado_d = RES_NONE;
    end else begin
      case (state_q)
        OFF: begin
          if (btn_power) begin
            state_d = WLCM;
            timer_d = '0;
          end
        end
        WLCM: begin
          if (btn_start || timer_q == TIMER_W'(T_WLCM - 1)) begin
            state_d = CH;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        CH: begin
          if (btn_start) begin
            state_d     = GAME;
            paso_d      = '0;
            mundo_d     = 2'd0;
            puntaje_d   = 8'd0;
            resultado_d = RES_NONE;
          end else if (btn_select) begin
            personaje_d = siguiente_personaje(personaje);
          end
        end
        GAME: begin
          if (bono_flanco && puntaje != 8'hFF) puntaje_d = puntaje + 8'd1;
          // A collision result swallows any tick arriving in the same cycle.
          if (wl_s != 2'b00) begin
            state_d     = WL;
            timer_d     = '0;
            resultado_d = (wl_s == RES_WON) ? RES_WON : RES_LOST;
          end else if (btn_pausa) begin
            state_d = PA;
          end else if (tick_obs) begin
            if (paso_q == PASO_W'(PASOS_MUNDO - 1)) begin
              paso_d = '0;
              if (mundo != 2'd3) mundo_d = mundo + 2'd1;
            end else begin
              paso_d = paso_q + PASO_W'(1);
            end
          end
        end
        PA: begin
          if (btn_pausa) state_d = GAME;
        end
        WL: begin
          if (btn_start) begin
            state_d = CH;
            timer_d = '0;
          end else if (timer_q == TIMER_W'(T_WL - 1)) begin
            state_d = WLCM;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_control_juego.sv
// Scoreboard bench for control_juego with small timing parameters.
module tb_control_juego;

  localparam int unsigned PM   = 4;
  localparam int unsigned TWC  = 20;
  localparam int unsigned TWLP = 30;

  localparam int K_PRES = 0, K_MUNDO = 1, K_PERS = 2, K_PUNT = 3, K_RES = 4, K_EN = 5, K_PASO = 6;
  localparam int B_POWER = 0, B_START = 1, B_PAUSA = 2, B_SELECT = 3, B_TICK = 4;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_power, btn_start, btn_pausa, btn_select, tick_obs;
  logic [1:0] W_or_L;
  logic       bono_tomado;
  logic [2:0] presente;
  logic [1:0] mundo, personaje, resultado;
  logic [7:0] puntaje;
  logic       en_obs;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t e_m;

  control_juego #(.PASOS_MUNDO(PM), .T_WLCM(TWC), .T_WL(TWLP)) dut (
    .clk(clk), .rst(rst),
    .btn_power(btn_power), .btn_start(btn_start), .btn_pausa(btn_pausa),
    .btn_select(btn_select), .tick_obs(tick_obs),
    .W_or_L(W_or_L), .bono_tomado(bono_tomado),
    .presente(presente), .mundo(mundo), .personaje(personaje),
    .puntaje(puntaje), .resultado(resultado), .en_obs(en_obs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int actual(input int k);
    case (k)
      K_PRES:  return int'(presente);
      K_MUNDO: return int'(mundo);
      K_PERS:  return int'(personaje);
      K_PUNT:  return int'(puntaje);
      K_RES:   return int'(resultado);
      K_EN:    return int'(en_obs);
      default: return int'(dut.paso_q);
    endcase
  endfunction

  // Monitor: compare every expectation due by this cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_m = sb.pop_front();
      n_vec++;
      if (actual(e_m.kind) != e_m.val) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e_m.name, actual(e_m.kind), e_m.val, cyc);
      end
    end
  end

  task automatic expect_v(input int k, input int v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int b);
    case (b)
      B_POWER:  btn_power  = 1'b1;
      B_START:  btn_start  = 1'b1;
      B_PAUSA:  btn_pausa  = 1'b1;
      B_SELECT: btn_select = 1'b1;
      default:  tick_obs   = 1'b1;
    endcase
    step(1);
    btn_power = 1'b0; btn_start = 1'b0; btn_pausa = 1'b0; btn_select = 1'b0; tick_obs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    btn_power = 1'b0; btn_start = 1'b0; btn_pausa = 1'b0; btn_select = 1'b0; tick_obs = 1'b0;
    W_or_L = 2'b00; bono_tomado = 1'b0;
    step(2);
    rst = 1'b0;
    expect_v(K_PRES, 0, "rst_presente");
    expect_v(K_MUNDO, 0, "rst_mundo");
    expect_v(K_PERS, 0, "rst_personaje");
    expect_v(K_PUNT, 0, "rst_puntaje");
    expect_v(K_RES, 0, "rst_resultado");
    expect_v(K_EN, 0, "rst_en_obs");
    expect_v(K_PASO, 0, "rst_paso");

    // Flow: power, start, select x4, start
    press(B_POWER);  expect_v(K_PRES, 1, "flow_wlcm");
    press(B_START);  expect_v(K_PRES, 2, "flow_ch");
    repeat (4) press(B_SELECT);
    expect_v(K_PERS, 1, "flow_personaje");
    press(B_START);
    expect_v(K_PRES, 3, "flow_game");
    expect_v(K_EN, 1, "flow_en_obs");
    expect_v(K_MUNDO, 0, "flow_mundo");

    // Worlds: advance at ticks 4, 8, 12; saturate at 3
    for (int i = 1; i <= 13; i++) begin
      press(B_TICK);
      if (i == 3)  expect_v(K_MUNDO, 0, "world_t3");
      if (i == 4)  expect_v(K_MUNDO, 1, "world_t4");
      if (i == 8)  expect_v(K_MUNDO, 2, "world_t8");
      if (i == 12) expect_v(K_MUNDO, 3, "world_t12");
      if (i == 13) expect_v(K_MUNDO, 3, "world_t13_sat");
    end
    expect_v(K_PASO, 1, "world_paso");

    // Bonus held high counts once
    bono_tomado = 1'b1; step(10); bono_tomado = 1'b0; step(3);
    expect_v(K_PUNT, 1, "bono_held");

    // Pause freezes progress
    press(B_PAUSA);
    expect_v(K_PRES, 5, "pausa_pa");
    expect_v(K_EN, 0, "pausa_en_obs");
    bono_tomado = 1'b1; step(3); bono_tomado = 1'b0;
    press(B_TICK); press(B_TICK); press(B_SELECT); step(3);
    expect_v(K_PUNT, 1, "pausa_puntaje");
    expect_v(K_MUNDO, 3, "pausa_mundo");
    expect_v(K_PASO, 1, "pausa_paso");
    expect_v(K_PERS, 1, "pausa_personaje");
    press(B_PAUSA);
    expect_v(K_PRES, 3, "pausa_resume");

    // Saturation
    repeat (300) begin
      bono_tomado = 1'b1; step(1); bono_tomado = 1'b0; step(1);
    end
    step(3);
    expect_v(K_PUNT, 255, "bono_sat");

    // Collision: 3-edge latency, same-cycle tick discarded
    W_or_L = 2'b01;
    step(2);
    expect_v(K_PRES, 3, "col_not_yet");
    tick_obs = 1'b1; step(1); tick_obs = 1'b0;
    expect_v(K_PRES, 4, "col_wl");
    expect_v(K_RES, 1, "col_lost");
    expect_v(K_PASO, 1, "col_paso_hold");
    expect_v(K_EN, 0, "col_en_obs");
    expect_v(K_MUNDO, 3, "wl_mundo_hold");
    expect_v(K_PUNT, 255, "wl_puntaje_hold");
    W_or_L = 2'b00;

    // Result screen timeout, then welcome timeout
    step(TWLP - 1); expect_v(K_PRES, 4, "wl_before_timeout");
    step(1);        expect_v(K_PRES, 1, "wl_timeout");
    step(TWC - 1);  expect_v(K_PRES, 1, "wlcm_before_timeout");
    step(1);        expect_v(K_PRES, 2, "wlcm_timeout");

    press(B_START);
    expect_v(K_PRES, 3, "game2");
    expect_v(K_MUNDO, 0, "game2_mundo");
    expect_v(K_PUNT, 0, "game2_puntaje");
    expect_v(K_RES, 0, "game2_resultado");
    repeat (8) press(B_TICK);
    expect_v(K_MUNDO, 2, "game2_mundo2");

    // Reset mid-game
    rst = 1'b1; step(1); rst = 1'b0;
    expect_v(K_PRES, 0, "midrst_presente");
    expect_v(K_MUNDO, 0, "midrst_mundo");
    expect_v(K_PUNT, 0, "midrst_puntaje");
    expect_v(K_PERS, 0, "midrst_personaje");

    // Power beats a simultaneous win
    press(B_POWER); press(B_START); press(B_START);
    expect_v(K_PRES, 3, "pwr_game");
    W_or_L = 2'b10;
    step(2);
    btn_power = 1'b1; step(1); btn_power = 1'b0;
    W_or_L = 2'b00;
    expect_v(K_PRES, 0, "pwr_off");
    expect_v(K_RES, 0, "pwr_resultado");
    step(2);
    expect_v(K_PRES, 0, "pwr_stays_off");

    // 11 counts as lost; start leaves result screen early; then a win
    press(B_POWER); press(B_START); press(B_START);
    W_or_L = 2'b11; step(3);
    expect_v(K_PRES, 4, "w11_wl");
    expect_v(K_RES, 1, "w11_lost");
    W_or_L = 2'b00;
    press(B_START);
    expect_v(K_PRES, 2, "wl_start_early");
    step(2);
    press(B_START);
    W_or_L = 2'b10; step(3);
    expect_v(K_PRES, 4, "win_wl");
    expect_v(K_RES, 2, "win_resultado");
    W_or_L = 2'b00;

    step(3);
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_juego.md
CONTROL_JUEGO -- requirements
Module: control_juego

Interface
REQ-001 The block SHALL have parameter PASOS_MUNDO, default 32: obstacle ticks per world.
REQ-002 The block SHALL have parameter T_WLCM, default 50_000_000: clk cycles of welcome before auto-advance.
REQ-003 The block SHALL have parameter T_WL, default 150_000_000: clk cycles the win/lose screen is held.
REQ-004 The block SHALL have port clk, input, 1: the single system clock.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port btn_power, input, 1: one-cycle debounced pulse.
REQ-007 The block SHALL have port btn_start, input, 1: one-cycle debounced pulse.
REQ-008 The block SHALL have port btn_pausa, input, 1: one-cycle debounced pulse.
REQ-009 The block SHALL have port btn_select, input, 1: one-cycle debounced pulse.
REQ-010 The block SHALL have port tick_obs, input, 1: one-cycle strobe per obstacle step, already in the clk domain.
REQ-011 The block SHALL have port W_or_L, input, 2: collision result, asynchronous to clk (00 none, 01 lost, 10 won).
REQ-012 The block SHALL have port bono_tomado, input, 2'b: no; input, 1: bonus level, asynchronous to clk.
REQ-013 The block SHALL have port presente, output, 3: current game state code.
REQ-014 The block SHALL have port mundo, output, 2: current world index, 0..3.
REQ-015 The block SHALL have port personaje, output, 2: selected character, 0..2.
REQ-016 The block SHALL have port puntaje, output, 8: bonus count.
REQ-017 The block SHALL have port resultado, output, 2: last game result (00 none, 01 lost, 10 won).
REQ-018 The block SHALL have port en_obs, output, 1: obstacle generator enable, high exactly when presente==GAME.

Function
REQ-019 State codes SHALL be OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5; codes 6 and 7 SHALL go to OFF on the next cycle.
REQ-020 W_or_L and bono_tomado SHALL pass through 2-flop synchronizers; decisions use the synchronized values (2-cycle latency).
REQ-021 Priority each cycle SHALL be btn_power > synchronized W_or_L != 00 (GAME only) > btn_pausa > tick_obs > btn_select/btn_start.
REQ-022 OFF: btn_power SHALL transition to WLCM; all other inputs SHALL be ignored.
REQ-023 In any state other than OFF, btn_power SHALL transition to OFF and clear mundo, puntaje, resultado and the timers on the next edge.
REQ-024 WLCM: btn_start, or the timer reaching T_WLCM-1, SHALL transition to CH; the timer SHALL clear on entry.
REQ-025 CH: btn_select SHALL advance personaje 0->1->2->0.
REQ-026 CH: btn_start SHALL transition to GAME and clear mundo, paso, puntaje and resultado.
REQ-027 GAME: tick_obs SHALL increment paso; at paso==PASOS_MUNDO-1, paso SHALL wrap to 0 and mundo SHALL increment.
REQ-028 mundo SHALL saturate at 3, with no further increments.
REQ-029 GAME: synchronized W_or_L==01 SHALL set resultado=01 and transition to WL.
REQ-030 GAME: synchronized W_or_L==10 SHALL set resultado=10 and transition to WL.
REQ-031 GAME: synchronized W_or_L==11 SHALL be treated as 01.
REQ-032 A tick_obs arriving in the same cycle as a W_or_L transition SHALL be discarded.
REQ-033 GAME: a rising edge of synchronized bono_tomado SHALL increment puntaje, saturating at 255; a held level SHALL count once.
REQ-034 GAME: btn_pausa SHALL transition to PA.
REQ-035 PA: btn_pausa SHALL return to GAME.
REQ-036 PA: tick_obs, W_or_L and bono edges SHALL be ignored, and paso, mundo and puntaje SHALL hold.
REQ-037 WL: the timer reaching T_WL-1 SHALL transition to WLCM.
REQ-038 WL: btn_start SHALL transition to CH early.
REQ-039 WL: mundo and puntaje SHALL hold for display.
REQ-040 Outputs SHALL be registered; presente SHALL change on the edge after the qualifying input.

Reset
REQ-041 rst SHALL force presente=OFF, mundo=0, personaje=0, puntaje=0, resultado=00, en_obs=0, paso=0, timers=0 and synchronizer flops=0.
REQ-042 rst SHALL take precedence over every input in the same cycle, including mid-GAME and mid-WL.

Structure
REQ-043 The state codes OFF..PA SHALL live in the shared package heroe_pkg, used also by the collision checker.
REQ-044 The 2-flop synchronizer SHALL be a sub-module named sincronizador, instantiated once per bit (3 instances).
REQ-045 The timer SHALL be a single 28-bit counter shared by WLCM and WL.
REQ-046 paso SHALL be $clog2(PASOS_MUNDO) bits wide.

Verification
REQ-047 Reset test: rst mid-GAME with mundo=2 -> next cycle presente=0, mundo=0, puntaje=0.
REQ-048 Flow test: power, start, select x4, start -> presente=3, personaje=1, en_obs=1.
REQ-049 World test (PASOS_MUNDO=4): 13 tick_obs in GAME -> mundo 0->1->2->3 at ticks 4, 8 and 12, and mundo stays 3 at tick 13.
REQ-050 Collision test: W_or_L=01 asserted -> presente=4, resultado=01 exactly 3 clk edges later; a tick_obs in the transition cycle leaves paso unchanged.
REQ-051 Bonus test: bono_tomado held high for 10 cycles -> puntaje +1.
REQ-052 Pause/saturation test: 300 bonus pulses -> puntaje=255; in PA, bono and tick_obs change nothing.
REQ-053 Power test: btn_power together with W_or_L=10 in GAME -> presente=OFF, resultado=00.
